// File: rtl/serial_rx_framed.sv
// serial_rx_framed: framed serial packet receiver.
// Takes a 2-flop synchronised rx line through start, PKT_LENGTH data bits and
// STOP_BITS stop bits, then presents the packet through a one-deep
// valid/ready holding register. Reports framing errors and overruns.
// Optional parity bit: define SERIAL_RX_FRAMED_PARITY_EN.
module serial_rx_framed #(
   parameter int CLK_PER_BIT = 50,
   parameter int PKT_LENGTH  = 32,
   parameter bit IDLE_LEVEL  = 1'b0,
   parameter int MSB_FIRST   = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic [PKT_LENGTH-1:0] data,
   output logic                  valid,
   input  logic                  ready,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  parity_err
);

   localparam int CW   = $clog2(CLK_PER_BIT) + 1;
   localparam int BW   = $clog2(PKT_LENGTH + 1);
   localparam int HALF = CLK_PER_BIT / 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef SERIAL_RX_FRAMED_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t                state_q, state_d;
   logic                  rx_meta_q, rx_s_q;
   logic [CW-1:0]         ctr_q, ctr_d;
   logic [BW-1:0]         bitcnt_q, bitcnt_d;
   logic [PKT_LENGTH-1:0] sr_q, sr_d, sr_shift;
   logic                  stop_idx_q, stop_idx_d;
   logic                  par_bad_q, par_bad_d;
   logic [PKT_LENGTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  busy_q;
   logic                  frame_err_q, frame_err_d;
   logic                  overrun_q, overrun_d;
   logic                  parity_err_q, parity_err_d;
   logic                  ctr_last;
   logic                  pkt_done;

   // Shift-register insertion point depends on bit order.
   generate
      if (PKT_LENGTH == 1) begin : g_sr1
         assign sr_shift = rx_s_q;
      end else if (MSB_FIRST != 0) begin : g_msb
         assign sr_shift = {sr_q[PKT_LENGTH-2:0], rx_s_q};
      end else begin : g_lsb
         assign sr_shift = {rx_s_q, sr_q[PKT_LENGTH-1:1]};
      end
   endgenerate

   assign ctr_last = (ctr_q == CW'(CLK_PER_BIT - 1));

   // Next-state, bit sampling, and holding-register update.
   always_comb begin
      state_d      = state_q;
      ctr_d        = ctr_q;
      bitcnt_d     = bitcnt_q;
      sr_d         = sr_q;
      stop_idx_d   = stop_idx_q;
      par_bad_d    = par_bad_q;
      data_d       = data_q;
      valid_d      = valid_q && !ready;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
      parity_err_d = 1'b0;
      pkt_done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            ctr_d      = '0;
            bitcnt_d   = '0;
            stop_idx_d = 1'b0;
            par_bad_d  = 1'b0;
            if (rx_s_q != IDLE_LEVEL) state_d = S_START;
         end
         S_START: begin
            // Mid-start re-check rejects short glitches silently.
            if (ctr_q == CW'(HALF)) begin
               ctr_d   = '0;
               state_d = (rx_s_q != IDLE_LEVEL) ? S_DATA : S_IDLE;
            end else begin
               ctr_d = ctr_q + 1'b1;
            end
         end
         S_DATA: begin
            if (ctr_last) begin
               ctr_d    = '0;
               sr_d     = sr_shift;
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == BW'(PKT_LENGTH - 1)) begin
`ifdef SERIAL_RX_FRAMED_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               ctr_d = ctr_q + 1'b1;
            end
         end
`ifdef SERIAL_RX_FRAMED_PARITY_EN
         S_PARITY: begin
            // Even parity: data bits plus parity bit must XOR to zero.
            if (ctr_last) begin
               ctr_d   = '0;
               state_d = S_STOP;
               if ((^sr_q) ^ rx_s_q) begin
                  parity_err_d = 1'b1;
                  par_bad_d    = 1'b1;
               end
            end else begin
               ctr_d = ctr_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            // A parity-failed packet still runs stop checks but reports nothing more.
            if (ctr_last) begin
               ctr_d = '0;
               if (rx_s_q != IDLE_LEVEL) begin
                  frame_err_d = !par_bad_q;
                  state_d     = S_WAIT_IDLE;
               end else if (STOP_BITS == 1 || stop_idx_q) begin
                  pkt_done = !par_bad_q;
                  state_d  = S_IDLE;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end else begin
               ctr_d = ctr_q + 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            if (rx_s_q == IDLE_LEVEL) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Load wins over a same-cycle consume; a full, unconsumed register drops the new packet.
      if (pkt_done) begin
         if (!valid_q || ready) begin
            data_d  = sr_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State and output registers; synchroniser resets to idle so reset never looks like a start.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q    <= IDLE_LEVEL;
         rx_s_q       <= IDLE_LEVEL;
         state_q      <= S_IDLE;
         ctr_q        <= '0;
         bitcnt_q     <= '0;
         sr_q         <= '0;
         stop_idx_q   <= 1'b0;
         par_bad_q    <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         state_q      <= state_d;
         ctr_q        <= ctr_d;
         bitcnt_q     <= bitcnt_d;
         sr_q         <= sr_d;
         stop_idx_q   <= stop_idx_d;
         par_bad_q    <= par_bad_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         busy_q       <= (state_d != S_IDLE);
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign data       = data_q;
   assign valid      = valid_q;
   assign busy       = busy_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign parity_err = parity_err_q;

endmodule

// File: tb/tb_serial_rx_framed.sv
// Bench for serial_rx_framed: two instances (LSB-first and MSB-first) share
// one rx line; a scoreboard queue per instance holds expected packets.
module tb_serial_rx_framed;

   localparam int CPB = 16;
   localparam int N   = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rx = 1'b0;
   logic         ready = 1'b1;
   logic [N-1:0] data_l, data_m;
   logic         valid_l, valid_m, busy_l, busy_m;
   logic         fe_l, fe_m, ov_l, ov_m, pe_l, pe_m;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] q_l[$];
   logic [N-1:0] q_m[$];
   int fe_cnt_l = 0, fe_cnt_m = 0, ov_cnt_l = 0, ov_cnt_m = 0, pe_cnt_l = 0, pe_cnt_m = 0;

   always #5 clk = ~clk;

   serial_rx_framed #(.CLK_PER_BIT(CPB), .PKT_LENGTH(N), .IDLE_LEVEL(1'b0),
                      .MSB_FIRST(0), .STOP_BITS(1)) u_lsb (
      .clk(clk), .rst(rst), .rx(rx), .data(data_l), .valid(valid_l), .ready(ready),
      .busy(busy_l), .frame_err(fe_l), .overrun(ov_l), .parity_err(pe_l));

   serial_rx_framed #(.CLK_PER_BIT(CPB), .PKT_LENGTH(N), .IDLE_LEVEL(1'b0),
                      .MSB_FIRST(1), .STOP_BITS(1)) u_msb (
      .clk(clk), .rst(rst), .rx(rx), .data(data_m), .valid(valid_m), .ready(ready),
      .busy(busy_m), .frame_err(fe_m), .overrun(ov_m), .parity_err(pe_m));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0] rev(input logic [N-1:0] v);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = v[N-1-i];
      return r;
   endfunction

   // Monitor: pop and compare on every handshake, tally error pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid_l && ready) begin
            if (q_l.size() == 0) check("unexpected_valid_lsb", {31'b0, valid_l}, 32'd0);
            else check("data_lsb", {24'b0, data_l}, {24'b0, q_l.pop_front()});
         end
         if (valid_m && ready) begin
            if (q_m.size() == 0) check("unexpected_valid_msb", {31'b0, valid_m}, 32'd0);
            else check("data_msb", {24'b0, data_m}, {24'b0, q_m.pop_front()});
         end
         fe_cnt_l += int'(fe_l); fe_cnt_m += int'(fe_m);
         ov_cnt_l += int'(ov_l); ov_cnt_m += int'(ov_m);
         pe_cnt_l += int'(pe_l); pe_cnt_m += int'(pe_m);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      tick(CPB);
   endtask

   // v[i] is the i-th data bit on the wire.
   task automatic send_frame(input logic [N-1:0] v, input logic stop_lvl, input logic par_flip);
      send_bit(1'b1);
      for (int i = 0; i < N; i++) begin
         send_bit(v[i]);
         if (i == 3) begin
            check("busy_mid_lsb", {31'b0, busy_l}, 32'd1);
            check("busy_mid_msb", {31'b0, busy_m}, 32'd1);
         end
      end
`ifdef SERIAL_RX_FRAMED_PARITY_EN
      send_bit((^v) ^ par_flip);
`else
      if (par_flip) rx = 1'b0;
`endif
      send_bit(stop_lvl);
   endtask

   task automatic expect_pkt(input logic [N-1:0] v);
      q_l.push_back(v);
      q_m.push_back(rev(v));
   endtask

   initial begin
      tick(4);
      // reset state
      check("rst_valid", {31'b0, valid_l}, 32'd0);
      check("rst_busy", {31'b0, busy_l}, 32'd0);
      check("rst_data", {24'b0, data_l}, 32'd0);
      check("rst_errs", {29'b0, fe_l, ov_l, pe_l}, 32'd0);
      rst = 1'b0;
      tick(CPB);

      // basic frame: 1,0,1,1,0,0,1,0 -> 4D (LSB first) / B2 (MSB first)
      expect_pkt(8'h4D);
      send_frame(8'h4D, 1'b0, 1'b0);
      tick(CPB);
      check("busy_after_frame", {31'b0, busy_l}, 32'd0);
      check("basic_q_drained", q_l.size(), 32'd0);

      // 5-clk glitch: no output, no errors, back to idle
      rx = 1'b1;
      tick(5);
      rx = 1'b0;
      tick(3 * CPB);
      check("glitch_busy", {31'b0, busy_l}, 32'd0);
      check("glitch_fe", fe_cnt_l, 32'd0);

      // wrong-level stop bit, line held active, then back to idle
      send_frame(8'h4D, 1'b1, 1'b0);
      tick(2 * CPB);
      check("fe_busy_held_lsb", {31'b0, busy_l}, 32'd1);
      check("fe_busy_held_msb", {31'b0, busy_m}, 32'd1);
      check("fe_count_lsb", fe_cnt_l, 32'd1);
      check("fe_count_msb", fe_cnt_m, 32'd1);
      check("fe_no_valid", {31'b0, valid_l}, 32'd0);
      rx = 1'b0;
      tick(3 * CPB);
      check("fe_busy_released", {31'b0, busy_l}, 32'd0);

      // overrun: ready low, two packets, second dropped
      ready = 1'b0;
      expect_pkt(8'h4D);
      send_frame(8'h4D, 1'b0, 1'b0);
      tick(4);
      check("ovr_valid_first", {31'b0, valid_l}, 32'd1);
      send_frame(8'h12, 1'b0, 1'b0);
      tick(4);
      check("ovr_count_lsb", ov_cnt_l, 32'd1);
      check("ovr_count_msb", ov_cnt_m, 32'd1);
      check("ovr_data_lsb", {24'b0, data_l}, 32'h4D);
      check("ovr_data_msb", {24'b0, data_m}, 32'hB2);
      check("ovr_valid_held", {31'b0, valid_l}, 32'd1);
      ready = 1'b1;
      tick(1);
      check("ovr_valid_dropped", {31'b0, valid_l}, 32'd0);
      check("ovr_q_drained", q_l.size(), 32'd0);
      tick(CPB);

      // reset mid-DATA after 4 bits, then a clean A5 frame
      send_bit(1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rst = 1'b1;
      rx  = 1'b0;
      tick(3);
      check("midrst_busy", {31'b0, busy_l}, 32'd0);
      check("midrst_valid", {31'b0, valid_l}, 32'd0);
      check("midrst_data", {24'b0, data_l}, 32'd0);
      rst = 1'b0;
      tick(CPB);
      expect_pkt(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b0);
      tick(CPB);
      check("a5_q_drained_lsb", q_l.size(), 32'd0);
      check("a5_q_drained_msb", q_m.size(), 32'd0);

`ifdef SERIAL_RX_FRAMED_PARITY_EN
      // wrong parity bit: parity_err only, no frame_err, no output
      send_frame(8'h3C, 1'b0, 1'b1);
      tick(CPB);
      check("par_count_lsb", pe_cnt_l, 32'd1);
      check("par_count_msb", pe_cnt_m, 32'd1);
      check("par_no_fe", fe_cnt_l, 32'd1);
      check("par_no_valid", {31'b0, valid_l}, 32'd0);
`else
      check("par_tied_low", pe_cnt_l + pe_cnt_m, 32'd0);
`endif

      // final totals
      check("total_fe", fe_cnt_l, 32'd1);
      check("total_ov", ov_cnt_l, 32'd1);
      check("final_q_l", q_l.size(), 32'd0);
      check("final_q_m", q_m.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
